array_alloc_arbiter: RTL and testbench

ARRAY_ALLOC_ARBITER -- requirements
Module: array_alloc_arbiter

---
 rtl/array_alloc_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_array_alloc_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_alloc_arbiter.sv
// rtl/array_alloc_arbiter.sv - two-requester array allocator with freed-array reuse stack
// and per-array high-water size tracking.
module array_alloc_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    reqValid,
  input  logic [1:0]                    reqFree,
  input  logic [MemoryElementWidth-1:0] reqArray0,
  input  logic [MemoryElementWidth-1:0] reqArray1,
  output logic [1:0]                    ack,
  output logic [MemoryElementWidth-1:0] respArray,
  output logic                          respError,
  input  logic                          sizeWe,
  input  logic [MemoryElementWidth-1:0] sizeArray,
  input  logic [MemoryElementWidth-1:0] sizeIndex,
  input  logic [MemoryElementWidth-1:0] sizeRdArray,
  output logic [MemoryElementWidth-1:0] sizeRdData,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic [MemoryElementWidth-1:0] inUse
);

  localparam int W = MemoryElementWidth;
  localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int Depth = 1 << IW;
  localparam logic [W-1:0] NArr = W'(NArrays);
  localparam logic [W-1:0] One = W'(1);
  localparam logic [W-1:0] SizeMax = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic           win_q, win_d;
  logic           op_free_q, op_free_d;
  logic [W-1:0]   op_array_q, op_array_d;
  logic [W-1:0]   allocs_q, allocs_d;
  logic [W-1:0]   in_use_q, in_use_d;
  logic [W-1:0]   freed_top_q, freed_top_d;
  logic [Depth-1:0] freed_flag_q, freed_flag_d;
  logic [W-1:0]   freed_arrays_q [Depth];
  logic [W-1:0]   freed_arrays_d [Depth];
  logic [W-1:0]   array_sizes_q [Depth];
  logic [W-1:0]   array_sizes_d [Depth];
  logic [1:0]     ack_q, ack_d;
  logic [W-1:0]   resp_array_q, resp_array_d;
  logic           resp_error_q, resp_error_d;

  logic [W:0]     size_inc;
  logic [W-1:0]   size_new;
  logic [IW-1:0]  size_idx;
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  op_idx;
  logic [IW-1:0]  pop_idx;
  logic [IW-1:0]  push_idx;

  // Index+1 is formed one bit wider so the all-ones index saturates instead of wrapping to 0.
  always_comb begin
    size_inc = {1'b0, sizeIndex} + (W+1)'(1);
    size_new = size_inc[W] ? SizeMax : size_inc[W-1:0];
    size_idx = sizeArray[IW-1:0];
    rd_idx   = sizeRdArray[IW-1:0];
    op_idx   = op_array_q[IW-1:0];
    pop_idx  = freed_top_q[IW-1:0] - IW'(1);
    push_idx = freed_top_q[IW-1:0];
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    win_d          = win_q;
    op_free_d      = op_free_q;
    op_array_d     = op_array_q;
    allocs_d       = allocs_q;
    in_use_d       = in_use_q;
    freed_top_d    = freed_top_q;
    freed_flag_d   = freed_flag_q;
    freed_arrays_d = freed_arrays_q;
    array_sizes_d  = array_sizes_q;
    ack_d          = 2'b00;
    resp_array_d   = resp_array_q;
    resp_error_d   = resp_error_q;

    // Size tracking runs first so a same-cycle allocate clear below overrides it.
    if (sizeWe && (sizeArray < NArr) && (array_sizes_q[size_idx] < size_new)) begin
      array_sizes_d[size_idx] = size_new;
    end

    case (state_q)
      IDLE: begin
        if (reqValid != 2'b00) begin
          win_d      = (reqValid == 2'b11) ? ~last_q : reqValid[1];
          op_free_d  = reqFree[win_d];
          op_array_d = win_d ? reqArray1 : reqArray0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d      = RESP;
        ack_d        = win_q ? 2'b10 : 2'b01;
        resp_error_d = 1'b0;
        resp_array_d = '0;
        if (!op_free_q) begin
          if (freed_top_q != '0) begin
            resp_array_d = freed_arrays_q[pop_idx];
            freed_top_d  = freed_top_q - One;
            freed_flag_d[resp_array_d[IW-1:0]] = 1'b0;
          end else if (allocs_q < NArr) begin
            resp_array_d = allocs_q;
            allocs_d     = allocs_q + One;
          end else begin
            resp_error_d = 1'b1;
          end
          if (!resp_error_d) begin
            array_sizes_d[resp_array_d[IW-1:0]] = '0;
            in_use_d = in_use_q + One;
          end
        end else if ((op_array_q >= allocs_q) || freed_flag_q[op_idx]) begin
          resp_error_d = 1'b1;
        end else begin
          freed_arrays_d[push_idx] = op_array_q;
          freed_top_d  = freed_top_q + One;
          freed_flag_d[op_idx] = 1'b1;
          in_use_d     = in_use_q - One;
          resp_array_d = op_array_q;
        end
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      win_q          <= 1'b0;
      op_free_q      <= 1'b0;
      op_array_q     <= '0;
      allocs_q       <= '0;
      in_use_q       <= '0;
      freed_top_q    <= '0;
      freed_flag_q   <= '0;
      freed_arrays_q <= '{default: '0};
      array_sizes_q  <= '{default: '0};
      ack_q          <= 2'b00;
      resp_array_q   <= '0;
      resp_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      win_q          <= win_d;
      op_free_q      <= op_free_d;
      op_array_q     <= op_array_d;
      allocs_q       <= allocs_d;
      in_use_q       <= in_use_d;
      freed_top_q    <= freed_top_d;
      freed_flag_q   <= freed_flag_d;
      freed_arrays_q <= freed_arrays_d;
      array_sizes_q  <= array_sizes_d;
      ack_q          <= ack_d;
      resp_array_q   <= resp_array_d;
      resp_error_q   <= resp_error_d;
    end
  end

  assign ack        = ack_q;
  assign respArray  = resp_array_q;
  assign respError  = resp_error_q;
  assign allocs     = allocs_q;
  assign inUse      = in_use_q;
  assign sizeRdData = (sizeRdArray < NArr) ? array_sizes_q[rd_idx] : '0;

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// tb/tb_array_alloc_arbiter.sv - directed and randomized bench for array_alloc_arbiter
// against a queue-based allocation model.
module tb_array_alloc_arbiter;

  localparam int W = 12;
  localparam int NA = 4;
  localparam int SMAX = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    reqValid, reqFree;
  logic [W-1:0]  reqArray0, reqArray1;
  logic [1:0]    ack;
  logic [W-1:0]  respArray;
  logic          respError;
  logic          sizeWe;
  logic [W-1:0]  sizeArray, sizeIndex, sizeRdArray, sizeRdData, allocs, inUse;

  array_alloc_arbiter #(.MemoryElementWidth(W), .NArrays(NA)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqFree(reqFree),
    .reqArray0(reqArray0), .reqArray1(reqArray1),
    .ack(ack), .respArray(respArray), .respError(respError),
    .sizeWe(sizeWe), .sizeArray(sizeArray), .sizeIndex(sizeIndex),
    .sizeRdArray(sizeRdArray), .sizeRdData(sizeRdData),
    .allocs(allocs), .inUse(inUse)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: allocation bookkeeping plus a simple service timeline.
  int cyc = 0;
  int m_allocs, m_inuse, m_last;
  int m_size [NA];
  bit m_freed [NA];
  int m_stack [$];
  int s_win, s_arr, exec_t, ready_t;
  bit s_free;
  bit rnd_req = 0;
  bit rnd_size = 0;
  int ack_arr [2];
  int ack_err [2];
  int ack_cyc [2];

  task automatic model_reset();
    m_allocs = 0; m_inuse = 0; m_last = 1;
    m_stack.delete();
    for (int i = 0; i < NA; i++) begin m_size[i] = 0; m_freed[i] = 0; end
    exec_t = -1; ready_t = 0;
  endtask

  task automatic model_exec(output int arr, output int err);
    arr = 0; err = 0;
    if (!s_free) begin
      if (m_stack.size() > 0) begin arr = m_stack.pop_back(); m_freed[arr] = 0; end
      else if (m_allocs < NA) begin arr = m_allocs; m_allocs++; end
      else err = 1;
      if (err == 0) begin m_size[arr] = 0; m_inuse++; end
    end else if (s_arr >= m_allocs || m_freed[s_arr]) begin
      err = 1;
    end else begin
      m_stack.push_back(s_arr); m_freed[s_arr] = 1; m_inuse--; arr = s_arr;
    end
  endtask

  task automatic issue(input int r, input bit fr, input int arr);
    reqValid[r] = 1'b1;
    reqFree[r]  = fr;
    if (r == 0) reqArray0 = arr[W-1:0]; else reqArray1 = arr[W-1:0];
  endtask

  // One clock: account for the rising edge just passed, check outputs, then drive new inputs.
  task automatic step();
    int exp_ack, e_arr, e_err, w, v, rd;
    @(negedge clock);
    cyc++;
    exp_ack = 0; e_arr = 0; e_err = 0;
    if (reset) begin
      model_reset();
    end else begin
      if (sizeWe && sizeArray < NA) begin
        v = int'(sizeIndex) + 1;
        if (v > SMAX) v = SMAX;
        if (m_size[sizeArray] < v) m_size[sizeArray] = v;
      end
      if (exec_t == cyc) begin
        model_exec(e_arr, e_err);
        exp_ack = 1 << s_win;
        m_last = s_win;
        exec_t = -1;
      end else if (cyc >= ready_t && reqValid != 2'b00) begin
        w = (reqValid == 2'b11) ? 1 - m_last : (reqValid[1] ? 1 : 0);
        s_win = w; s_free = reqFree[w]; s_arr = w ? int'(reqArray1) : int'(reqArray0);
        exec_t = cyc + 1; ready_t = cyc + 3;
      end
    end
    check("ack", ack, exp_ack);
    if (exp_ack != 0) begin
      check("resp_error", respError, e_err);
      if (!(s_free && e_err != 0)) check("resp_array", respArray, e_arr);
      check("allocs", allocs, m_allocs);
      check("in_use", inUse, m_inuse);
      ack_arr[s_win] = int'(respArray);
      ack_err[s_win] = int'(respError);
      ack_cyc[s_win] = cyc;
      reqValid[s_win] = 1'b0;
    end
    rd = (sizeRdArray < NA) ? m_size[sizeRdArray] : 0;
    check("size_rd", sizeRdData, rd);
    if (rnd_size) begin
      sizeWe      = 1'($urandom_range(0, 1));
      sizeArray   = W'($urandom_range(0, 5));
      sizeIndex   = ($urandom_range(0, 7) == 0) ? W'(SMAX) : W'($urandom_range(0, 20));
      sizeRdArray = W'($urandom_range(0, 5));
    end
    if (rnd_req) begin
      reset = ($urandom_range(0, 599) == 0);
      for (int r = 0; r < 2; r++)
        if (!reqValid[r] && $urandom_range(0, 2) == 0)
          issue(r, $urandom_range(0, 9) < 4, $urandom_range(0, 5));
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((reqValid != 2'b00 || exec_t != -1) && k < 40) begin step(); k++; end
    check("drain_bound", (reqValid != 2'b00 || exec_t != -1), 0);
  endtask

  task automatic wait_sampled();
    int k = 0;
    while (exec_t == -1 && k < 10) begin step(); k++; end
    check("sample_bound", exec_t == -1, 0);
  endtask

  int c0;

  initial begin
    reqValid = 0; reqFree = 0; reqArray0 = 0; reqArray1 = 0;
    sizeWe = 0; sizeArray = 0; sizeIndex = 0; sizeRdArray = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) step();
    check("rst_ack", ack, 0);
    check("rst_resp_array", respArray, 0);
    check("rst_resp_error", respError, 0);
    check("rst_allocs", allocs, 0);
    check("rst_in_use", inUse, 0);
    check("rst_size", sizeRdData, 0);
    reset = 1'b0;

    // single allocate from reset
    c0 = cyc;
    issue(0, 0, 0); drain();
    check("first_alloc_arr", ack_arr[0], 0);
    check("first_alloc_latency", ack_cyc[0] - c0, 2);
    check("first_alloc_allocs", allocs, 1);
    check("first_alloc_in_use", inUse, 1);

    // simultaneous allocate from reset
    reset = 1'b1; step(); step(); reset = 1'b0;
    issue(0, 0, 0); issue(1, 0, 0); drain();
    check("tie_arr0", ack_arr[0], 0);
    check("tie_arr1", ack_arr[1], 1);
    check("tie_spacing", ack_cyc[1] - ack_cyc[0], 3);

    // exhaust then overflow
    issue(0, 0, 0); drain();
    issue(1, 0, 0); drain();
    issue(0, 0, 0); drain();
    check("overflow_err", ack_err[0], 1);
    check("overflow_arr", ack_arr[0], 0);
    check("overflow_allocs", allocs, 4);

    // double free then reuse
    sizeWe = 1; sizeArray = 2; sizeIndex = 9; sizeRdArray = 2; step(); sizeWe = 0; step();
    check("pre_free_size", sizeRdData, 10);
    issue(1, 1, 2); drain();
    check("free_ok", ack_err[1], 0);
    check("free_arr", ack_arr[1], 2);
    check("free_in_use", inUse, 3);
    issue(1, 1, 2); drain();
    check("double_free_err", ack_err[1], 1);
    issue(0, 0, 0); drain();
    check("reuse_arr", ack_arr[0], 2);
    check("reuse_size", sizeRdData, 0);
    check("reuse_in_use", inUse, 4);

    // size tracking, ignore of out-of-range, saturation
    sizeRdArray = 0; sizeWe = 1; sizeArray = 0;
    sizeIndex = 0; step(); sizeIndex = 1; step(); sizeIndex = 2; step(); sizeIndex = 1; step();
    sizeWe = 0; step();
    check("size_hwm", sizeRdData, 3);
    sizeWe = 1; sizeArray = 5; sizeIndex = 50; step(); sizeWe = 0; sizeRdArray = 5; step();
    check("size_oor", sizeRdData, 0);
    sizeWe = 1; sizeArray = 3; sizeIndex = W'(SMAX); sizeRdArray = 3; step();
    sizeIndex = W'(SMAX - 1); step(); sizeWe = 0; step();
    check("size_sat", sizeRdData, SMAX);

    // size write colliding with allocate clear
    issue(0, 1, 1); drain();
    issue(0, 0, 0); wait_sampled();
    sizeWe = 1; sizeArray = 1; sizeIndex = 7; sizeRdArray = 1; step();
    sizeWe = 0; step();
    check("clear_prio_arr", ack_arr[0], 1);
    check("clear_prio_size", sizeRdData, 0);

    // reset mid-operation, then re-issue
    issue(1, 0, 0); wait_sampled();
    reset = 1'b1; step(); step();
    check("abort_allocs", allocs, 0);
    reset = 1'b0;
    drain();
    check("reissue_arr", ack_arr[1], 0);
    check("reissue_allocs", allocs, 1);

    // randomized traffic
    rnd_req = 1; rnd_size = 1;
    repeat (4000) step();
    rnd_req = 0; rnd_size = 0; reset = 1'b0; sizeWe = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
